// File: rtl/tile_pkg.sv
// ============================================================================
// Module   : tile_pkg
// Purpose  : Shared tile types and sizes for the drain path and tile controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tile_pkg;

  localparam int ROWS       = 4;
  localparam int LANES      = 4;
  localparam int OMEM_AW    = 4;
  localparam int DW_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CALC   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/drain_wb_stage.sv
// ============================================================================
// Module   : drain_wb_stage
// Purpose  : Row capture register and OMEM writeback (overwrite or lane-wise add).
// Revision : 1.0
// ============================================================================
`default_nettype none

module drain_wb_stage
  import tile_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  i_cap,
  input  logic                  i_flush,
  input  logic                  i_acc,
  input  logic [OMEM_AW-1:0]    i_addr,
  input  logic [LANES*DW-1:0]   i_row,
  input  logic [LANES*DW-1:0]   i_rdata,
  output logic                  o_wen,
  output logic [OMEM_AW-1:0]    o_waddr,
  output logic [LANES*DW-1:0]   o_wdata
);

  logic [LANES*DW-1:0] row_q, row_d;
  logic [OMEM_AW-1:0]  addr_q, addr_d;
  logic                acc_q, acc_d;
  logic                vld_q, vld_d;
  logic [LANES*DW-1:0] lane_sum;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      row_q  <= '0;
      addr_q <= '0;
      acc_q  <= 1'b0;
      vld_q  <= 1'b0;
    end else begin
      row_q  <= row_d;
      addr_q <= addr_d;
      acc_q  <= acc_d;
      vld_q  <= vld_d;
    end
  end

  always_comb begin
    row_d  = row_q;
    addr_d = addr_q;
    acc_d  = acc_q;
    vld_d  = 1'b0;
    if (i_flush) begin
      row_d  = '0;
      addr_d = '0;
      acc_d  = 1'b0;
    end else if (i_cap) begin
      vld_d  = 1'b1;
      row_d  = i_row;
      addr_d = i_addr;
      acc_d  = i_acc;
    end
  end

  // Independent lane adders: carries never cross a DW boundary.
  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign lane_sum[l*DW +: DW] = row_q[l*DW +: DW] + i_rdata[l*DW +: DW];
    end
  endgenerate

  assign o_wen   = vld_q;
  assign o_waddr = addr_q;
  assign o_wdata = !vld_q ? '0 : (acc_q ? lane_sum : row_q);

endmodule

`default_nettype wire

// File: rtl/tile_drain_ctrl.sv
// ============================================================================
// Module   : tile_drain_ctrl
// Purpose  : Drains the 4 MAC-array result rows into OMEM after each tile.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tile_drain_ctrl
  import tile_pkg::*;
#(
  parameter int DW  = DW_DEFAULT,
  parameter int LAT = 3
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  START_CALC,
  input  logic                  ACC,
  input  logic [OMEM_AW-1:0]    ODST,
  input  logic                  CLR_DP,
  output logic [1:0]            ROW_SEL,
  input  logic [LANES*DW-1:0]   ARR_ROW,
  output logic                  O_REN,
  output logic [OMEM_AW-1:0]    O_RADDR,
  input  logic [LANES*DW-1:0]   O_RDATA,
  output logic                  O_WEN,
  output logic [OMEM_AW-1:0]    O_WADDR,
  output logic [LANES*DW-1:0]   O_WDATA,
  output logic                  TILE_DONE,
  output logic                  OVERRUN
);

  // The CALC cycle that sees START_CALC low is settle cycle 0.
  localparam logic [2:0] SETTLE_LOAD = (LAT > 1) ? 3'(LAT - 2) : 3'd0;

  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [1:0]         row_q, row_d;
  logic [OMEM_AW-1:0] base_q, base_d;
  logic               acc_q, acc_d;
  logic               ovr_q, ovr_d;
  logic               start_prev_q, start_prev_d;

  logic               busy;
  logic               flush;
  logic               cap;
  logic               ren;
  logic               done;
  logic [1:0]         row_sel;
  logic [OMEM_AW-1:0] raddr;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      row_q        <= '0;
      base_q       <= '0;
      acc_q        <= 1'b0;
      ovr_q        <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      row_q        <= row_d;
      base_q       <= base_d;
      acc_q        <= acc_d;
      ovr_q        <= ovr_d;
      start_prev_q <= start_prev_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    row_d        = row_q;
    base_d       = base_q;
    acc_d        = acc_q;
    start_prev_d = START_CALC;
    row_sel      = 2'd0;
    ren          = 1'b0;
    raddr        = '0;
    cap          = 1'b0;
    done         = 1'b0;
    busy         = (state_q == ST_SETTLE) || (state_q == ST_DRAIN) ||
                   (state_q == ST_FLUSH)  || (state_q == ST_DONE);
    flush        = CLR_DP && (state_q != ST_IDLE);
    ovr_d        = ovr_q | (START_CALC & ~start_prev_q & busy);

    case (state_q)
      ST_IDLE: begin
        if (START_CALC && !CLR_DP) begin
          state_d = ST_CALC;
          acc_d   = ACC;
          base_d  = {ODST[OMEM_AW-1:2], 2'b00};
          row_d   = 2'd0;
        end
      end
      ST_CALC: begin
        if (!START_CALC) begin
          cnt_d   = SETTLE_LOAD;
          state_d = (LAT > 1) ? ST_SETTLE : ST_DRAIN;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DRAIN: begin
        row_sel = row_q;
        cap     = 1'b1;
        ren     = acc_q;
        raddr   = acc_q ? (base_q + OMEM_AW'(row_q)) : '0;
        row_d   = row_q + 2'd1;
        if (row_q == 2'd3) begin
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: state_d = ST_DONE;
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort: the write already leaving the stage this cycle still lands.
    if (flush) begin
      state_d = ST_IDLE;
      cap     = 1'b0;
      ren     = 1'b0;
      raddr   = '0;
      done    = 1'b0;
    end
  end

  drain_wb_stage #(
    .DW (DW)
  ) u_wb (
    .CLK     (CLK),
    .RSTN    (RSTN),
    .i_cap   (cap),
    .i_flush (flush),
    .i_acc   (acc_q),
    .i_addr  (base_q + OMEM_AW'(row_q)),
    .i_row   (ARR_ROW),
    .i_rdata (O_RDATA),
    .o_wen   (O_WEN),
    .o_waddr (O_WADDR),
    .o_wdata (O_WDATA)
  );

  assign ROW_SEL   = row_sel;
  assign O_REN     = ren;
  assign O_RADDR   = raddr;
  assign TILE_DONE = done;
  assign OVERRUN   = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_tile_drain_ctrl.sv
// ============================================================================
// Module   : tb_tile_drain_ctrl
// Purpose  : Directed vector bench for tile_drain_ctrl (DW=16, LAT=3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tile_drain_ctrl;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        START_CALC;
  logic        ACC;
  logic [3:0]  ODST;
  logic        CLR_DP;
  logic [1:0]  ROW_SEL;
  logic [63:0] ARR_ROW;
  logic        O_REN;
  logic [3:0]  O_RADDR;
  logic [63:0] O_RDATA;
  logic        O_WEN;
  logic [3:0]  O_WADDR;
  logic [63:0] O_WDATA;
  logic        TILE_DONE;
  logic        OVERRUN;

  tile_drain_ctrl #(.DW(16), .LAT(3)) dut (
    .CLK        (CLK),
    .RSTN       (RSTN),
    .START_CALC (START_CALC),
    .ACC        (ACC),
    .ODST       (ODST),
    .CLR_DP     (CLR_DP),
    .ROW_SEL    (ROW_SEL),
    .ARR_ROW    (ARR_ROW),
    .O_REN      (O_REN),
    .O_RADDR    (O_RADDR),
    .O_RDATA    (O_RDATA),
    .O_WEN      (O_WEN),
    .O_WADDR    (O_WADDR),
    .O_WDATA    (O_WDATA),
    .TILE_DONE  (TILE_DONE),
    .OVERRUN    (OVERRUN)
  );

  always #5 CLK = ~CLK;

  // OMEM model: synchronous read, preload port for test setup.
  logic [63:0]      mem [16];
  logic             pl_en;
  logic [3:0]       pl_addr;
  logic [63:0]      pl_data;
  logic [3:0][63:0] arr_pat;

  always @(posedge CLK) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (O_WEN) mem[O_WADDR] <= O_WDATA;
    if (O_REN) O_RDATA <= mem[O_RADDR];
  end

  always_comb ARR_ROW = arr_pat[ROW_SEL];

  typedef struct packed {
    int               hi_len;
    int               pulse_c;
    logic [3:0]       odst;
    logic             acc;
    logic [63:0]      mem_init;
    logic [3:0][63:0] arr;
    logic [3:0]       exp_base;
    logic [3:0][63:0] exp_wd;
    logic [15:0]      exp_wen;
    logic [15:0]      exp_ren;
    logic [15:0]      exp_done;
    logic [15:0]      exp_ovr;
  } vec_t;

  vec_t        vec [4];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] wen_m, ren_m, done_m, ovr_m;
  logic [3:0]  waddr_log [16];
  logic [63:0] wdata_log [16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [63:0] d);
    @(posedge CLK); #1;
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge CLK); #1;
    pl_en = 1'b0;
  endtask

  // Cycle 0 is the first cycle with START_CALC low after the high window.
  task automatic run_tile(input int hi_len, input logic [3:0] odst, input logic acc,
                          input int pulse_c, input int clr_c, input int rst_c);
    wen_m = '0; ren_m = '0; done_m = '0; ovr_m = '0;
    for (int i = 0; i < 16; i++) begin
      waddr_log[i] = '0;
      wdata_log[i] = '0;
    end
    for (int c = -hi_len; c <= 12; c++) begin
      @(posedge CLK); #1;
      START_CALC = (c < 0) || (c == pulse_c);
      CLR_DP     = (c == clr_c);
      RSTN       = (c != rst_c);
      ODST       = odst;
      ACC        = acc;
      @(negedge CLK);
      if (c == rst_c) begin
        chk("reset_mid_ctrl", 64'({O_WEN, O_REN, TILE_DONE, OVERRUN, ROW_SEL, O_RADDR, O_WADDR}), 64'd0);
        chk("reset_mid_wdata", O_WDATA, 64'd0);
      end
      if (c >= 0) begin
        wen_m[c]     = O_WEN;
        ren_m[c]     = O_REN;
        done_m[c]    = TILE_DONE;
        ovr_m[c]     = OVERRUN;
        waddr_log[c] = O_WADDR;
        wdata_log[c] = O_WDATA;
      end
    end
    START_CALC = 1'b0;
    CLR_DP     = 1'b0;
    RSTN       = 1'b1;
  endtask

  task automatic apply_vec(input int v);
    for (int r = 0; r < 4; r++) preload(vec[v].exp_base + 4'(r), vec[v].mem_init);
    arr_pat = vec[v].arr;
    run_tile(vec[v].hi_len, vec[v].odst, vec[v].acc, vec[v].pulse_c, 99, 99);
    chk($sformatf("v%0d_wen", v),  64'(wen_m),  64'(vec[v].exp_wen));
    chk($sformatf("v%0d_ren", v),  64'(ren_m),  64'(vec[v].exp_ren));
    chk($sformatf("v%0d_done", v), 64'(done_m), 64'(vec[v].exp_done));
    chk($sformatf("v%0d_ovr", v),  64'(ovr_m),  64'(vec[v].exp_ovr));
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("v%0d_waddr%0d", v, r), 64'(waddr_log[4+r]), 64'(vec[v].exp_base + 4'(r)));
      chk($sformatf("v%0d_wdata%0d", v, r), wdata_log[4+r], vec[v].exp_wd[r]);
      chk($sformatf("v%0d_mem%0d", v, r), mem[vec[v].exp_base + 4'(r)], vec[v].exp_wd[r]);
    end
  endtask

  initial begin
    // 0: overwrite, rows 1..4 per lane
    vec[0].hi_len = 4; vec[0].pulse_c = 99; vec[0].odst = 4'b0100; vec[0].acc = 1'b0;
    vec[0].mem_init = 64'hDEAD_BEEF_CAFE_F00D;
    for (int r = 0; r < 4; r++) begin
      vec[0].arr[r]    = 64'h0001_0001_0001_0001 * 64'(r + 1);
      vec[0].exp_wd[r] = 64'h0001_0001_0001_0001 * 64'(r + 1);
    end
    vec[0].exp_base = 4'd4; vec[0].exp_wen = 16'h00F0; vec[0].exp_ren = 16'h0000;
    vec[0].exp_done = 16'h0100; vec[0].exp_ovr = 16'h0000;
    // 1: accumulate 5 + 3
    vec[1].hi_len = 2; vec[1].pulse_c = 99; vec[1].odst = 4'd8; vec[1].acc = 1'b1;
    vec[1].mem_init = 64'h0005_0005_0005_0005;
    for (int r = 0; r < 4; r++) begin
      vec[1].arr[r]    = 64'h0003_0003_0003_0003;
      vec[1].exp_wd[r] = 64'h0008_0008_0008_0008;
    end
    vec[1].exp_base = 4'd8; vec[1].exp_wen = 16'h00F0; vec[1].exp_ren = 16'h0078;
    vec[1].exp_done = 16'h0100; vec[1].exp_ovr = 16'h0000;
    // 2: lane wrap, 1-cycle start, ODST low bits ignored, top addresses
    vec[2].hi_len = 1; vec[2].pulse_c = 99; vec[2].odst = 4'hF; vec[2].acc = 1'b1;
    vec[2].mem_init = 64'h1234_FFFF_0000_7FFF;
    for (int r = 0; r < 4; r++) begin
      vec[2].arr[r]    = 64'h0001_0002_FFFF_8001;
      vec[2].exp_wd[r] = 64'h1235_0001_FFFF_0000;
    end
    vec[2].exp_base = 4'd12; vec[2].exp_wen = 16'h00F0; vec[2].exp_ren = 16'h0078;
    vec[2].exp_done = 16'h0100; vec[2].exp_ovr = 16'h0000;
    // 3: overrun pulse in cycle 5, tile unaffected
    vec[3] = vec[0];
    vec[3].pulse_c = 5; vec[3].exp_ovr = 16'h1FC0;

    RSTN = 1'b0; START_CALC = 1'b0; ACC = 1'b0; ODST = '0; CLR_DP = 1'b0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0; arr_pat = '0; O_RDATA = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    #3;
    chk("reset_ctrl", 64'({O_WEN, O_REN, TILE_DONE, OVERRUN, ROW_SEL, O_RADDR, O_WADDR}), 64'd0);
    chk("reset_wdata", O_WDATA, 64'd0);
    @(posedge CLK); @(posedge CLK); #1;
    RSTN = 1'b1;

    for (int v = 0; v < 4; v++) apply_vec(v);

    // Reset in the middle of the drain, then a fresh 1-cycle tile.
    arr_pat = vec[0].arr;
    run_tile(4, 4'b0100, 1'b0, 99, 99, 5);
    chk("rst_mid_wen", 64'(wen_m), 64'h0010);
    chk("rst_mid_done", 64'(done_m), 64'h0000);
    run_tile(1, 4'b0100, 1'b0, 99, 99, 99);
    chk("post_rst_done", 64'(done_m), 64'h0100);
    chk("post_rst_wen", 64'(wen_m), 64'h00F0);
    chk("post_rst_ovr", 64'(ovr_m), 64'h0000);

    // Abort in DRAIN r=2: the r=1 write in cycle 5 lands, nothing after.
    run_tile(4, 4'b0100, 1'b0, 99, 5, 99);
    chk("abort_wen", 64'(wen_m), 64'h0030);
    chk("abort_done", 64'(done_m), 64'h0000);
    chk("abort_waddr5", 64'(waddr_log[5]), 64'd5);
    apply_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
